// File: rtl/jk_exc_if.sv
// Target handshake between sequencing control and the JK excitation driver.
interface jk_exc_if #(
    parameter int WIDTH = 4
);
    logic             tgt_valid;
    logic             tgt_ready;
    logic [WIDTH-1:0] tgt_data;

    modport master (
        output tgt_valid,
        output tgt_data,
        input  tgt_ready
    );

    modport slave (
        input  tgt_valid,
        input  tgt_data,
        output tgt_ready
    );
endinterface

// File: rtl/jk_exc_driver.sv
// Drives a bank of JK flops toward a target word, checks readback and retries.
// Optional macro JK_TOGGLE_EXC_EN selects toggle excitation (J=K=1) for changing bits.
module jk_exc_driver #(
    parameter int WIDTH      = 4,
    parameter int SETTLE_CYC = 2,
    parameter int MAX_RETRY  = 3
) (
    input  logic             clk,
    input  logic             rst,
    jk_exc_if.slave          tgt,
    input  logic [WIDTH-1:0] q_fb,
    output logic [WIDTH-1:0] j,
    output logic [WIDTH-1:0] k,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam int SW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [SW-1:0] SETTLE_LOAD = SW'(SETTLE_CYC - 1);
    localparam logic [3:0]    MAX_R       = 4'(MAX_RETRY);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DRIVE,
        S_SETTLE,
        S_CHECK,
        S_ERR
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] tgt_r;
    logic [3:0]       retry_cnt;
    logic [SW-1:0]    settle_cnt;
    logic             ready_r;
    logic             accept;

    assign tgt.tgt_ready = ready_r;
    assign accept        = tgt.tgt_valid & ready_r;

    // Returns {J, K} for moving the bank from q to t.
    function automatic logic [2*WIDTH-1:0] excite(input logic [WIDTH-1:0] t,
                                                  input logic [WIDTH-1:0] q);
        logic [WIDTH-1:0] jv;
        logic [WIDTH-1:0] kv;
`ifdef JK_TOGGLE_EXC_EN
        jv = t ^ q;
        kv = t ^ q;
`else
        jv = t & ~q;
        kv = ~t & q;
`endif
        return {jv, kv};
    endfunction

    function automatic logic [3:0] retry_inc(input logic [3:0] r);
        return (r >= MAX_R) ? MAX_R : r + 4'd1;
    endfunction

    // Target word is pure data: captured on accept, no reset needed.
    always_ff @(posedge clk) begin
        if (accept) begin
            tgt_r <= tgt.tgt_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            j          <= '0;
            k          <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            ready_r    <= 1'b1;
            retry_cnt  <= 4'd0;
            settle_cnt <= '0;
        end else begin
            done <= 1'b0;
            j    <= '0;
            k    <= '0;
            case (state)
                S_IDLE, S_ERR: begin
                    if (accept) begin
                        state     <= S_DRIVE;
                        {j, k}    <= excite(tgt.tgt_data, q_fb);
                        retry_cnt <= 4'd0;
                        err       <= 1'b0;
                        busy      <= 1'b1;
                        ready_r   <= 1'b0;
                    end
                end
                S_DRIVE: begin
                    state      <= S_SETTLE;
                    settle_cnt <= SETTLE_LOAD;
                end
                S_SETTLE: begin
                    if (settle_cnt == '0) begin
                        state <= S_CHECK;
                    end else begin
                        settle_cnt <= settle_cnt - SW'(1);
                    end
                end
                S_CHECK: begin
                    if (q_fb == tgt_r) begin
                        state   <= S_IDLE;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        ready_r <= 1'b1;
                    end else if (retry_cnt < MAX_R) begin
                        // Re-derive from the current readback, not the original sample.
                        state     <= S_DRIVE;
                        retry_cnt <= retry_inc(retry_cnt);
                        {j, k}    <= excite(tgt_r, q_fb);
                    end else begin
                        state   <= S_ERR;
                        err     <= 1'b1;
                        busy    <= 1'b0;
                        ready_r <= 1'b1;
                    end
                end
                default: begin
                    state   <= S_IDLE;
                    busy    <= 1'b0;
                    ready_r <= 1'b1;
                end
            endcase
        end
    end

endmodule
